// File: rtl/instr_word_encoder_if.sv
// Field-bundle handshake between the program source and instr_word_encoder.
// The master drives one decoded instruction per accepted cycle; the slave
// (the encoder) answers with in_ready.
interface instr_word_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_nop;
  logic [3:0]  in_cond;
  logic [2:0]  in_class;
  logic [3:0]  in_opcode;
  logic        in_s;
  logic        in_byte;
  logic        in_link;
  logic [3:0]  in_rn;
  logic [3:0]  in_rd;
  logic [11:0] in_operand;
  logic [23:0] in_offset;

  modport master (
    output in_valid, in_nop, in_cond, in_class, in_opcode, in_s, in_byte,
           in_link, in_rn, in_rd, in_operand, in_offset,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_nop, in_cond, in_class, in_opcode, in_s, in_byte,
           in_link, in_rn, in_rd, in_operand, in_offset,
    output in_ready
  );
endinterface

// File: rtl/instr_word_encoder.sv
// instr_word_encoder: packs instruction field bundles into 32-bit ARM-format
// words and writes each word big-endian, one byte per cycle, to a byte-wide
// instruction RAM write port. Acts as program loader ahead of the IF stage.
// Optional feature macro: INSTR_ENC_CHECKSUM_EN adds a running XOR of every
// completed word on the checksum output.
module instr_word_encoder #(
  parameter int ADDR_W      = 8,
  parameter int BASE_ADDR   = 0,
  parameter int DEPTH_WORDS = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load_start,
  instr_word_encoder_if.slave bus,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [7:0]          mem_data,
  output logic                mem_we,
  output logic [ADDR_W-2:0]   word_count,
  output logic                full,
  output logic                err
`ifdef INSTR_ENC_CHECKSUM_EN
  ,
  output logic [31:0]         checksum
`endif
);

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-2:0] DEPTH_C  = (ADDR_W-1)'(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-2:0] CNT_ONE  = {{(ADDR_W-2){1'b0}}, 1'b1};
  localparam logic [ADDR_W-2:0] CNT_ZERO = {(ADDR_W-1){1'b0}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_B0   = 3'd1,
    S_B1   = 3'd2,
    S_B2   = 3'd3,
    S_B3   = 3'd4,
    S_FULL = 3'd5
  } state_t;

  // Pack one field bundle into its 32-bit instruction word.
  function automatic logic [31:0] encode_word(
    input logic        nop,
    input logic [3:0]  cond,
    input logic [2:0]  cls,
    input logic [3:0]  opcode,
    input logic        s,
    input logic        byte_b,
    input logic        link,
    input logic [3:0]  rn,
    input logic [3:0]  rd,
    input logic [11:0] operand,
    input logic [23:0] offset
  );
    logic [31:0] w;
    if (nop) begin
      w = 32'h0000_0000;
    end else begin
      case (cls)
        // Load/store: pre-indexed, up, no write-back
        3'b010, 3'b011: w = {cond, cls, 1'b1, 1'b1, byte_b, 1'b0, s, rn, rd, operand};
        3'b101:         w = {cond, cls, link, offset};
        // Data processing and block transfer share one layout
        default:        w = {cond, cls, opcode, s, rn, rd, operand};
      endcase
    end
    return w;
  endfunction

  state_t            state_q, state_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              we_q, we_d;
  logic [ADDR_W-2:0] count_q, count_d;
  logic              full_q, full_d;
  logic              err_q, err_d;

  logic              ready_s;
  logic              accept_s;
  logic              illegal_s;
  logic              writing_s;
  logic [ADDR_W-2:0] count_inc_s;
  logic [31:0]       encoded_s;

  assign ready_s     = (state_q == S_IDLE) & ~full_q & ~load_start;
  assign accept_s    = bus.in_valid & ready_s;
  assign illegal_s   = ~bus.in_nop & (bus.in_class[2:1] == 2'b11);
  assign writing_s   = (state_q == S_B0) | (state_q == S_B1) |
                       (state_q == S_B2) | (state_q == S_B3);
  assign count_inc_s = count_q + CNT_ONE;
  assign encoded_s   = encode_word(bus.in_nop, bus.in_cond, bus.in_class, bus.in_opcode,
                                   bus.in_s, bus.in_byte, bus.in_link, bus.in_rn,
                                   bus.in_rd, bus.in_operand, bus.in_offset);

  // State register for the byte-sequencing FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: load_start rewinds from anywhere, otherwise walk B0..B3.
  always_comb begin
    state_d = state_q;
    if (load_start) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s & ~illegal_s) state_d = S_B0;
          else                       state_d = S_IDLE;
        end
        S_B0:   state_d = S_B1;
        S_B1:   state_d = S_B2;
        S_B2:   state_d = S_B3;
        S_B3: begin
          if (count_inc_s == DEPTH_C) state_d = S_FULL;
          else                        state_d = S_IDLE;
        end
        S_FULL: state_d = S_FULL;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output/datapath next values; the write strobe and byte follow state_d
  // so they appear registered on the cycle the FSM is in that byte state.
  always_comb begin
    word_d  = word_q;
    addr_d  = addr_q;
    count_d = count_q;
    full_d  = full_q;
    err_d   = 1'b0;
    if (load_start) begin
      addr_d  = BASE_A;
      count_d = CNT_ZERO;
      full_d  = 1'b0;
    end else begin
      if (accept_s & ~illegal_s) word_d = encoded_s;
      else                       word_d = word_q;
      if (writing_s) addr_d = addr_q + ADDR_ONE;
      else           addr_d = addr_q;
      if (state_q == S_B3) begin
        count_d = count_inc_s;
        full_d  = (count_inc_s == DEPTH_C);
      end else begin
        count_d = count_q;
        full_d  = full_q;
      end
      err_d = accept_s & illegal_s;
    end
    case (state_d)
      S_B0:    begin we_d = 1'b1; data_d = word_d[31:24]; end
      S_B1:    begin we_d = 1'b1; data_d = word_d[23:16]; end
      S_B2:    begin we_d = 1'b1; data_d = word_d[15:8];  end
      S_B3:    begin we_d = 1'b1; data_d = word_d[7:0];   end
      default: begin we_d = 1'b0; data_d = 8'h00;         end
    endcase
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q  <= 32'h0000_0000;
      addr_q  <= BASE_A;
      data_q  <= 8'h00;
      we_q    <= 1'b0;
      count_q <= CNT_ZERO;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      word_q  <= word_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

`ifdef INSTR_ENC_CHECKSUM_EN
  logic [31:0] cks_q, cks_d;

  // Fold each word in on its final byte; abandoned words never reach B3 commit.
  always_comb begin
    if (load_start)            cks_d = 32'h0000_0000;
    else if (state_q == S_B3)  cks_d = cks_q ^ word_q;
    else                       cks_d = cks_q;
  end

  // Checksum register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cks_q <= 32'h0000_0000;
    end else begin
      cks_q <= cks_d;
    end
  end

  assign checksum = cks_q;
`endif

  assign bus.in_ready = ready_s;
  assign mem_addr     = addr_q;
  assign mem_data     = data_q;
  assign mem_we       = we_q;
  assign word_count   = count_q;
  assign full         = full_q;
  assign err          = err_q;

endmodule
